output_stream_tx: RTL

- DUT-side transmitter for convolution results: the output half of the shared con_* bus that the input loader uses to receive data.
- Accepts 32-bit accumulations from the PE/accumulator stage, requantizes them to IO_DATA_WIDTH and buffers them in a FIFO.
- Takes ownership of the shared bus via driving_cons with turnaround cycles, then streams one result per beat on con_1, tagged with output_x/y/ch, under a valid/ready handshake.

---
 rtl/output_stream_tx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/output_stream_tx.sv
// output_stream_tx: requantizes 32-bit accumulations, buffers them in a FIFO
// and streams them onto the shared con_* bus once it has been taken over.
// Optional build macro: OUTPUT_STREAM_RELU_EN clamps negative results to zero.
module output_stream_tx #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int FEATURE_MAP_WIDTH  = 64,
  parameter int FEATURE_MAP_HEIGHT = 64,
  parameter int OUTPUT_NB_CHANNELS = 32,
  parameter int FIFO_DEPTH         = 8,
  parameter int BURST_THRESHOLD    = 4,
  parameter int OUT_SHIFT          = 8
) (
  input  logic                                  clk,
  input  logic                                  arst_n_in,
  input  logic                                  acc_valid,
  output logic                                  acc_ready,
  input  logic [ACCUMULATION_WIDTH-1:0]         acc_data,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  acc_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] acc_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] acc_ch,
  input  logic                                  acc_last,
  input  logic                                  bus_free,
  output logic [IO_DATA_WIDTH-1:0]              con_1,
  output logic [IO_DATA_WIDTH-1:0]              con_2,
  output logic [IO_DATA_WIDTH-1:0]              con_3,
  input  logic                                  con_ready,
  output logic                                  output_valid,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
  output logic                                  driving_cons,
  output logic                                  tx_busy
);

  localparam int DW  = IO_DATA_WIDTH;
  localparam int AW  = ACCUMULATION_WIDTH;
  localparam int XW  = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CHW = $clog2(OUTPUT_NB_CHANNELS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = DW + XW + YW + CHW;

  // Saturation bounds expressed at accumulation width; MIN is the bitwise
  // complement of MAX in two's complement.
  localparam logic signed [AW-1:0] SAT_MAX_C = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SAT_MIN_C = ~SAT_MAX_C;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TURN_ON  = 2'd1,
    ST_SEND     = 2'd2,
    ST_TURN_OFF = 2'd3
  } state_t;

  // Arithmetic shift followed by clamping into the output lane range.
  function automatic logic [DW-1:0] requant(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] sh;
    logic [DW-1:0]        r;
    sh = a >>> OUT_SHIFT;
`ifdef OUTPUT_STREAM_RELU_EN
    if (sh[AW-1]) begin
      r = {DW{1'b0}};
    end else if (sh > SAT_MAX_C) begin
      r = SAT_MAX_C[DW-1:0];
    end else begin
      r = sh[DW-1:0];
    end
`else
    if (sh > SAT_MAX_C) begin
      r = SAT_MAX_C[DW-1:0];
    end else if (sh < SAT_MIN_C) begin
      r = SAT_MIN_C[DW-1:0];
    end else begin
      r = sh[DW-1:0];
    end
`endif
    return r;
  endfunction

  state_t         state_r, state_nxt_s;
  logic [EW-1:0]  mem_r [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           pending_last_r;
  logic           push_s, pop_s, head_valid_s, drive_s, send_done_s;
  logic [EW-1:0]  head_s;

  assign acc_ready    = (count_r != CW'(FIFO_DEPTH));
  assign push_s       = acc_valid && acc_ready;
  assign head_valid_s = (state_r == ST_SEND) && (count_r != {CW{1'b0}});
  assign pop_s        = head_valid_s && con_ready;
  assign head_s       = mem_r[rd_ptr_r];

  // Result storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {requant($signed(acc_data)), acc_x, acc_y, acc_ch};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Remembers that the layer's final result is buffered so a short tail still flushes.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      pending_last_r <= 1'b0;
    end else if (push_s && acc_last) begin
      pending_last_r <= 1'b1;
    end else if (send_done_s) begin
      pending_last_r <= 1'b0;
    end else begin
      pending_last_r <= pending_last_r;
    end
  end

  // Bus ownership state register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus ownership sequencing: acquire, stream until drained, release with a gap.
  always_comb begin
    state_nxt_s = state_r;
    drive_s     = 1'b0;
    send_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus_free && ((count_r >= CW'(BURST_THRESHOLD)) ||
                         (pending_last_r && (count_r != {CW{1'b0}})))) begin
          state_nxt_s = ST_TURN_ON;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TURN_ON: begin
        drive_s     = 1'b1;
        state_nxt_s = ST_SEND;
      end
      ST_SEND: begin
        drive_s = 1'b1;
        if ((count_r == {CW{1'b0}}) || (pop_s && !push_s && (count_r == CW'(1)))) begin
          send_done_s = 1'b1;
          state_nxt_s = ST_TURN_OFF;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_TURN_OFF: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign driving_cons = drive_s;
  assign output_valid = head_valid_s;
  assign con_1        = head_valid_s ? head_s[EW-1 -: DW]          : {DW{1'b0}};
  assign output_x     = head_valid_s ? head_s[YW+CHW +: XW]        : {XW{1'b0}};
  assign output_y     = head_valid_s ? head_s[CHW +: YW]           : {YW{1'b0}};
  assign output_ch    = head_valid_s ? head_s[CHW-1:0]             : {CHW{1'b0}};
  assign con_2        = {DW{1'b0}};
  assign con_3        = {DW{1'b0}};
  assign tx_busy      = (count_r != {CW{1'b0}}) || (state_r != ST_IDLE);

endmodule
